// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_pkg
//  Description : Shared constants and types for the bit-serial arithmetic
//                cells. Holds the default operand width and the controller
//                state encoding used by serial_subtractor.
//  Contents    : ARITH_WIDTH  - default operand/result width
//                state_t      - controller states (2'd3 is unused/illegal)
//  Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    localparam int ARITH_WIDTH = 8;

    // 2'd3 is never entered deliberately; the controller treats it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Request/response bundle for the bit-serial subtractor.
//  Ports       : start       - request a new subtraction (master -> slave)
//                a, b        - minuend / subtrahend      (master -> slave)
//                busy        - operation is shifting     (slave -> master)
//                done        - one-cycle result strobe   (slave -> master)
//                diff        - a - b mod 2^WIDTH         (slave -> master)
//                borrow      - 1 when a < b, unsigned    (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface
`default_nettype wire

// File: rtl/half_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : half_subtractor
//  Description : One-bit half subtractor, computes x - y.
//  Ports       : x  - minuend bit
//                y  - subtrahend bit
//                d  - difference bit  (x ^ y)
//                bo - borrow out      (~x & y)
//  Revision    : 1.0 - initial release
// ============================================================================
module half_subtractor (
    input  wire logic x,
    input  wire logic y,
    output logic      d,
    output logic      bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial subtractor, diff = a - b over WIDTH cycles, LSB
//                first. One registered borrow bit feeds a full-subtract cell
//                made of two half subtractors. A start/busy/done handshake
//                accepts one operation at a time; a new start is accepted
//                in IDLE or in the DONE cycle (back-to-back).
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - serial_subtractor_if slave (start, a, b, busy, done,
//                       diff, borrow)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_subtractor_if.slave bus
);

    // One extra bit so the counter never wraps inside an operation.
    localparam int             CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  C_ONE  = CW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_bin;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_d0;
    logic             w_bo0;
    logic             w_d;
    logic             w_bo1;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_next;

    // ------------------------------------------------------------------
    // Full-subtract cell: x - y - bin.
    //   first stage : x - y
    //   second stage: (x ^ y) - bin
    //   bout        : either stage borrowed
    // ------------------------------------------------------------------
    half_subtractor u_hs_xy (
        .x  (r_sa[0]),
        .y  (r_sb[0]),
        .d  (w_d0),
        .bo (w_bo0)
    );

    half_subtractor u_hs_bin (
        .x  (w_d0),
        .y  (r_bin),
        .d  (w_d),
        .bo (w_bo1)
    );

    assign w_bout = w_bo0 | w_bo1;

    // Result register shifts right with the new bit entering at the MSB,
    // so after WIDTH shifts bit 0 holds the first (LSB) difference bit.
    // Written as shift-then-overwrite so WIDTH=1 needs no special case.
    always_comb begin
        w_res_next            = r_res >> 1;
        w_res_next[WIDTH-1]   = w_d;
    end

    // ------------------------------------------------------------------
    // Controller and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_bin    <= 1'b0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= ST_SHIFT;
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_res   <= '0;
                        r_bin   <= 1'b0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    r_res   <= w_res_next;
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_bin   <= w_bout;
                    r_count <= r_count + C_ONE;
                    // Outputs only move here, so partial results stay hidden.
                    if (r_count == C_LAST) begin
                        r_state  <= ST_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_diff   <= w_res_next;
                        r_borrow <= w_bout;
                    end
                end

                ST_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= ST_SHIFT;
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_res   <= '0;
                        r_bin   <= 1'b0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor (WIDTH=8).
//                Expected results come from plain 9-bit arithmetic:
//                {borrow, diff} = {1'b0, a} - {1'b0, b}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    import arith_pkg::*;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned subtraction with one extra bit for the borrow.
    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    // Issues one operation and watches it until done (bounded). Does no
    // checking itself; it reports what it saw.
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          output logic [WIDTH-1:0] od, output logic ob,
                          output int busy_cnt, output int done_idx,
                          output bit overlap, output bit unstable);
        logic [WIDTH-1:0] d0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        d0        = bus.diff;
        busy_cnt  = 0;
        done_idx  = 0;
        overlap   = 0;
        unstable  = 0;
        od        = '0;
        ob        = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.start = 1'b0;
                bus.a     = WIDTH'($urandom);
                bus.b     = WIDTH'($urandom);
            end
            if (bus.busy && bus.done) overlap = 1;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_idx = i;
                od       = bus.diff;
                ob       = bus.borrow;
                break;
            end
            if (bus.diff !== d0) unstable = 1;
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        bus.start = 1'bx;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_tests++; if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff got=%h exp=00", bus.diff); end
        n_tests++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL reset_borrow got=%b exp=0", bus.borrow); end
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_basic;
        logic [WIDTH-1:0] od;
        logic             ob;
        int               bc, di;
        bit               ov, us;
        run_op(8'h5A, 8'h3C, od, ob, bc, di, ov, us);
        n_tests++; if (od !== 8'h1E) begin n_fail++; $display("FAIL basic_diff got=%h exp=1e", od); end
        n_tests++; if (ob !== 1'b0) begin n_fail++; $display("FAIL basic_borrow got=%b exp=0", ob); end
        n_tests++; if (bc !== WIDTH) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, WIDTH); end
        n_tests++; if (di !== WIDTH + 1) begin n_fail++; $display("FAIL basic_done_latency got=%0d exp=%0d", di, WIDTH + 1); end
        n_tests++; if (ov !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done_overlap got=%b exp=0", ov); end
        n_tests++; if (us !== 1'b0) begin n_fail++; $display("FAIL basic_diff_stable got=%b exp=0", us); end
        @(negedge clk);
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_one_cycle got=%b exp=0", bus.done); end
        n_tests++; if (bus.diff !== 8'h1E) begin n_fail++; $display("FAIL basic_diff_held got=%h exp=1e", bus.diff); end
    endtask

    task automatic test_edges;
        logic [WIDTH-1:0] va [3] = '{8'h00, 8'hFF, 8'h80};
        logic [WIDTH-1:0] vb [3] = '{8'h01, 8'hFF, 8'h7F};
        logic [WIDTH-1:0] ed [3] = '{8'hFF, 8'h00, 8'h01};
        logic             eb [3] = '{1'b1, 1'b0, 1'b0};
        logic [WIDTH-1:0] od;
        logic             ob;
        int               bc, di;
        bit               ov, us;
        for (int k = 0; k < 3; k++) begin
            run_op(va[k], vb[k], od, ob, bc, di, ov, us);
            n_tests++; if (od !== ed[k]) begin n_fail++; $display("FAIL edge_diff[%0d] got=%h exp=%h", k, od, ed[k]); end
            n_tests++; if (ob !== eb[k]) begin n_fail++; $display("FAIL edge_borrow[%0d] got=%b exp=%b", k, ob, eb[k]); end
        end
    endtask

    task automatic test_start_ignored;
        int               dcnt;
        logic [WIDTH-1:0] gd;
        logic             gb;
        dcnt = 0;
        gd   = '0;
        gb   = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            if (i == 3) begin bus.start = 1'b1; bus.a = 8'h00; bus.b = 8'hFF; end
            if (i == 4) bus.start = 1'b0;
            if (bus.done) begin dcnt++; gd = bus.diff; gb = bus.borrow; end
        end
        n_tests++; if (dcnt !== 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", dcnt); end
        n_tests++; if (gd !== 8'h0F) begin n_fail++; $display("FAIL ignore_diff got=%h exp=0f", gd); end
        n_tests++; if (gb !== 1'b0) begin n_fail++; $display("FAIL ignore_borrow got=%b exp=0", gb); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_mid_reset;
        logic [WIDTH-1:0] od;
        logic             ob;
        int               bc, di, dcnt;
        bit               ov, us;
        // Leave a nonzero diff and a set borrow so the reset clear is visible.
        run_op(8'h00, 8'h01, od, ob, bc, di, ov, us);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h11;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
        n_tests++; if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL midrst_diff got=%h exp=00", bus.diff); end
        n_tests++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL midrst_borrow got=%b exp=0", bus.borrow); end
        dcnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcnt++;
        end
        n_tests++; if (dcnt !== 0) begin n_fail++; $display("FAIL midrst_activity got=%0d exp=0", dcnt); end
        run_op(8'h33, 8'h11, od, ob, bc, di, ov, us);
        n_tests++; if (od !== 8'h22) begin n_fail++; $display("FAIL midrst_fresh_diff got=%h exp=22", od); end
        n_tests++; if (ob !== 1'b0) begin n_fail++; $display("FAIL midrst_fresh_borrow got=%b exp=0", ob); end
    endtask

    task automatic test_back_to_back;
        int first, second;
        first  = 0;
        second = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h09; bus.b = 8'h04;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (first != 0 && i == first + 1) begin
                n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_after_done got=%b exp=1", bus.busy); end
            end
            if (bus.done) begin
                if (first == 0) begin
                    first = i;
                    n_tests++; if (bus.diff !== 8'h05) begin n_fail++; $display("FAIL b2b_diff1 got=%h exp=05", bus.diff); end
                    n_tests++; if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL b2b_borrow1 got=%b exp=0", bus.borrow); end
                    bus.a = 8'h04; bus.b = 8'h09;
                end else begin
                    second = i;
                    n_tests++; if (bus.diff !== 8'hFB) begin n_fail++; $display("FAIL b2b_diff2 got=%h exp=fb", bus.diff); end
                    n_tests++; if (bus.borrow !== 1'b1) begin n_fail++; $display("FAIL b2b_borrow2 got=%b exp=1", bus.borrow); end
                    break;
                end
            end
        end
        n_tests++; if (second - first !== WIDTH + 1 || first == 0) begin n_fail++; $display("FAIL b2b_period got=%0d exp=%0d", second - first, WIDTH + 1); end
        bus.start = 1'b0;
        repeat (WIDTH + 4) @(negedge clk);
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] ra, rb, od;
        logic [WIDTH:0]   exp;
        logic             ob;
        int               bc, di;
        bit               ov, us;
        for (int k = 0; k < 1000; k++) begin
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            exp = ref_sub(ra, rb);
            run_op(ra, rb, od, ob, bc, di, ov, us);
            n_tests++; if ({ob, od} !== exp || di !== WIDTH + 1) begin
                n_fail++; $display("FAIL rand_result a=%h b=%h got=%b_%h exp=%b_%h done_at=%0d", ra, rb, ob, od, exp[WIDTH], exp[WIDTH-1:0], di);
            end
            n_tests++; if (us !== 1'b0 || ov !== 1'b0) begin
                n_fail++; $display("FAIL rand_stable a=%h b=%h unstable=%b overlap=%b exp=0/0", ra, rb, us, ov);
            end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_basic();
        test_edges();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
